alu_seq: RTL and testbench

- Parametrised, sequential successor of the MU0 combinational ALU.
- Executes one ALU instruction per start pulse, single-cycle or multi-cycle, and owns its CARRY and SKIP flag registers.
- Adds multi-bit shifts (LSL/LSR by N) and an iterative shift-add multiply.
- Sits between register-file read ports and the Rd write port. The control FSM pulses `start` instead of using exec1 and waits for `done`.

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequential MU0 ALU with CARRY/SKIP flags, N-bit shifts and
//             iterative shift-add multiply; one instruction per start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [1:0]       cin_sel,
    input  logic             cw,
    input  logic [1:0]       cond,
    input  logic [WIDTH-1:0] rd,
    input  logic [WIDTH-1:0] rs,
    output logic [WIDTH-1:0] result,
    output logic             wen,
    output logic             busy,
    output logic             done,
    output logic             carry_q,
    output logic             skip_q
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MOV = 3'b010;
    localparam logic [2:0] c_OP_XSR = 3'b011;
    localparam logic [2:0] c_OP_LSL = 3'b100;
    localparam logic [2:0] c_OP_LSR = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;
    localparam logic [2:0] c_OP_RSV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [2:0]         r_op;
    logic               r_cw;
    logic [1:0]         r_cond;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;

    logic               w_cin;
    logic [CNTW-1:0]    w_amt;
    logic               w_multi;
    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_one_res;
    logic               w_one_cout;
    logic [WIDTH-1:0]   w_step_acc;
    logic               w_step_out;
    logic [2*WIDTH-1:0] w_step_prod;
    logic               w_run_last;
    logic               w_complete;
    logic [2:0]         w_fin_op;
    logic               w_fin_cw;
    logic [1:0]         w_fin_cond;
    logic [WIDTH-1:0]   w_fin_res;
    logic               w_fin_cout;
    logic               w_fin_skip;

    // Single-cycle datapath, evaluated straight from the ports in IDLE
    always_comb begin
        unique case (cin_sel)
            2'b00:   w_cin = 1'b0;
            2'b01:   w_cin = 1'b1;
            2'b10:   w_cin = carry_q;
            default: w_cin = rs[WIDTH-1];
        endcase
        w_amt   = rs[CNTW-1:0];
        w_multi = (((op == c_OP_LSL) || (op == c_OP_LSR)) && (w_amt != '0))
                  || (op == c_OP_MUL);
        w_add_a = (op == c_OP_MOV) ? '0  : rd;
        w_add_b = (op == c_OP_SUB) ? ~rs : rs;
        w_sum   = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};
        w_one_res  = '0;
        w_one_cout = 1'b0;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_MOV: begin
                w_one_res  = w_sum[WIDTH-1:0];
                w_one_cout = w_sum[WIDTH];
            end
            c_OP_XSR: begin
                w_one_res  = {w_cin, rs[WIDTH-1:1]};
                w_one_cout = rs[0];
            end
            c_OP_LSL, c_OP_LSR: w_one_res = rs;
            default: ;
        endcase
    end

    // Iterative step: r_acc is the shift value, or the multiplier for MUL
    always_comb begin
        w_step_out  = (r_op == c_OP_LSL) ? r_acc[WIDTH-1] : r_acc[0];
        w_step_acc  = (r_op == c_OP_LSL) ? {r_acc[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_acc[WIDTH-1:1]};
        w_step_prod = r_acc[0] ? (r_prod + r_mcand) : r_prod;
        w_run_last  = (r_op == c_OP_MUL) ? (r_cnt == '0) : (r_cnt == CNTW'(1));
    end

    always_comb begin
        if (r_state == RUN) begin
            w_fin_op   = r_op;
            w_fin_cw   = r_cw;
            w_fin_cond = r_cond;
            w_fin_res  = (r_op == c_OP_MUL) ? w_step_prod[WIDTH-1:0] : w_step_acc;
            w_fin_cout = (r_op == c_OP_MUL) ? (|w_step_prod[2*WIDTH-1:WIDTH])
                                            : w_step_out;
        end else begin
            w_fin_op   = op;
            w_fin_cw   = cw;
            w_fin_cond = cond;
            w_fin_res  = w_one_res;
            w_fin_cout = w_one_cout;
        end
        unique case (w_fin_cond)
            2'b00:   w_fin_skip = 1'b0;
            2'b01:   w_fin_skip = 1'b1;
            2'b10:   w_fin_skip = w_fin_cout;
            default: w_fin_skip = (w_fin_res == '0);
        endcase
        w_complete = ((r_state == IDLE) && start && !w_multi)
                     || ((r_state == RUN) && w_run_last);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = w_multi ? RUN : FIN;
            RUN:     if (w_run_last) w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // Outputs are registered on the edge entering FIN, so FIN is the done cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= '0;
            r_cw    <= 1'b0;
            r_cond  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            result  <= '0;
            wen     <= 1'b0;
            done    <= 1'b0;
            carry_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            wen  <= 1'b0;
            done <= 1'b0;
            if ((r_state == IDLE) && start) begin
                r_op    <= op;
                r_cw    <= cw;
                r_cond  <= cond;
                r_acc   <= rs;
                r_mcand <= {{WIDTH{1'b0}}, rd};
                r_prod  <= '0;
                r_cnt   <= (op == c_OP_MUL) ? CNTW'(WIDTH - 1) : w_amt;
            end else if (r_state == RUN) begin
                r_acc   <= w_step_acc;
                r_mcand <= r_mcand << 1;
                r_prod  <= w_step_prod;
                r_cnt   <= r_cnt - CNTW'(1);
            end
            if (w_complete) begin
                done <= 1'b1;
                if (w_fin_op == c_OP_RSV) begin
                    result <= '0;
                end else begin
                    result <= w_fin_res;
                    wen    <= 1'b1;
                    skip_q <= w_fin_skip;
                    if (w_fin_cw) carry_q <= w_fin_cout;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed scoreboard bench for alu_seq (WIDTH = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [1:0]  cin_sel = '0;
    logic        cw = 1'b0;
    logic [1:0]  cond = '0;
    logic [15:0] rd = '0;
    logic [15:0] rs = '0;
    logic [15:0] result;
    logic        wen, busy, done, carry_q, skip_q;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .cin_sel (cin_sel),
        .cw      (cw),
        .cond    (cond),
        .rd      (rd),
        .rs      (rs),
        .result  (result),
        .wen     (wen),
        .busy    (busy),
        .done    (done),
        .carry_q (carry_q),
        .skip_q  (skip_q)
    );

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        skip;
        logic        wen;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic mc = 1'b0;
    logic ms = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of one instruction against the bench's own flag copies
    function automatic exp_t model(input logic [2:0] o, input logic [1:0] cs, input logic cwv,
                                   input logic [1:0] cd, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic        cin;
        logic        cout;
        logic [16:0] s;
        logic [31:0] t;
        int          n;
        cin   = (cs == 2'd0) ? 1'b0 : (cs == 2'd1) ? 1'b1 : (cs == 2'd2) ? mc : b[15];
        n     = int'(b[3:0]);
        e.lat = 1;
        e.wen = 1'b1;
        e.res = '0;
        cout  = 1'b0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b} + 17'(cin); e.res = s[15:0]; cout = s[16]; end
            3'd1: begin s = {1'b0, a} + 17'h0FFFF - {1'b0, b} + 17'(cin); e.res = s[15:0]; cout = s[16]; end
            3'd2: begin s = {1'b0, b} + 17'(cin); e.res = s[15:0]; cout = s[16]; end
            3'd3: begin e.res = {cin, b[15:1]}; cout = b[0]; end
            3'd4: begin
                t = 32'(b) << n; e.res = t[15:0];
                cout = (n == 0) ? 1'b0 : t[16]; e.lat = n + 1;
            end
            3'd5: begin
                t = {b, 16'h0000} >> n; e.res = t[31:16];
                cout = (n == 0) ? 1'b0 : t[15]; e.lat = n + 1;
            end
            3'd6: begin
                t = 32'(a) * 32'(b); e.res = t[15:0];
                cout = (t[31:16] != 16'h0000); e.lat = 17;
            end
            default: e.wen = 1'b0;
        endcase
        if (o == 3'd7) begin
            e.carry = mc;
            e.skip  = ms;
        end else begin
            e.carry = cwv ? cout : mc;
            case (cd)
                2'd0:    e.skip = 1'b0;
                2'd1:    e.skip = 1'b1;
                2'd2:    e.skip = cout;
                default: e.skip = (e.res == 16'h0000);
            endcase
        end
        return e;
    endfunction

    // Issue one instruction; poke > 0 pulses start again in that cycle after the start
    task automatic do_op(input string tag, input logic [2:0] o, input logic [1:0] cs, input logic cwv,
                         input logic [1:0] cd, input logic [15:0] a, input logic [15:0] b, input int poke);
        exp_t e;
        exp_t got;
        int   cyc;
        int   extra;
        logic seen;
        @(negedge clk);
        op = o; cin_sel = cs; cw = cwv; cond = cd; rd = a; rs = b; start = 1'b1;
        e = model(o, cs, cwv, cd, a, b);
        sb.push_back(e);
        mc = e.carry;
        ms = e.skip;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
            if (cyc == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
            if (done) seen = 1'b1;
        end
        chk({tag, ".done"}, 32'(seen), 32'd1);
        got = sb.pop_front();
        chk({tag, ".lat"},    32'(cyc),     32'(got.lat));
        chk({tag, ".result"}, 32'(result),  32'(got.res));
        chk({tag, ".carry"},  32'(carry_q), 32'(got.carry));
        chk({tag, ".skip"},   32'(skip_q),  32'(got.skip));
        chk({tag, ".wen"},    32'(wen),     32'(got.wen));
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".pulse"}, 32'({done, wen, busy}), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || wen) extra++;
        end
        chk({tag, ".extra"}, 32'(extra), 32'd0);
        chk({tag, ".hold"}, 32'(result), 32'(got.res));
    endtask

    initial begin
        int   extra;
        logic [2:0]  ro;
        logic [15:0] ra, rb;

        repeat (2) @(negedge clk);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.flags", 32'({wen, busy, done, carry_q, skip_q}), 32'd0);
        reset_n = 1'b1;

        do_op("add_ovf",  3'd0, 2'd0, 1'b1, 2'd3, 16'hFFFF, 16'h0001, 0);
        do_op("sub",      3'd1, 2'd1, 1'b1, 2'd0, 16'h0005, 16'h0007, 0);
        do_op("add_cq",   3'd0, 2'd2, 1'b0, 2'd0, 16'h0001, 16'h0001, 0);
        do_op("lsl3",     3'd4, 2'd0, 1'b1, 2'd2, 16'h1234, 16'hC003, 0);
        do_op("lsr1",     3'd5, 2'd0, 1'b1, 2'd2, 16'h0000, 16'h0001, 0);
        do_op("mul_ovf",  3'd6, 2'd0, 1'b1, 2'd2, 16'h0100, 16'h0100, 5);
        do_op("mul_fin",  3'd6, 2'd0, 1'b0, 2'd3, 16'h1234, 16'h0003, 17);
        do_op("xsr_cw",   3'd3, 2'd3, 1'b1, 2'd0, 16'h0000, 16'h0003, 0);
        do_op("xsr_nocw", 3'd3, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0002, 0);
        do_op("rsv",      3'd7, 2'd0, 1'b1, 2'd1, 16'h0101, 16'h0202, 0);
        do_op("lsl0",     3'd4, 2'd0, 1'b1, 2'd3, 16'h0000, 16'h0010, 0);
        do_op("lsr15",    3'd5, 2'd0, 1'b1, 2'd0, 16'h0000, 16'h800F, 0);
        do_op("mov_cq",   3'd2, 2'd1, 1'b1, 2'd3, 16'h0000, 16'hFFFF, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_op("rand", ro, 2'($urandom), 1'($urandom), 2'($urandom), ra, rb, 0);
        end

        // Leave result/carry non-zero, then abort a multiply with reset
        do_op("pre_rst", 3'd0, 2'd0, 1'b1, 2'd0, 16'hFFFF, 16'h0003, 0);
        @(negedge clk);
        op = 3'd6; rd = 16'h00FF; rs = 16'h00FF; cw = 1'b1; cond = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort.result", 32'(result), 32'd0);
        chk("abort.flags", 32'({wen, busy, done, carry_q, skip_q}), 32'd0);
        #1 reset_n = 1'b1;
        mc = 1'b0;
        ms = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || wen || busy) extra++;
        end
        chk("abort.nodone", 32'(extra), 32'd0);

        do_op("post_rst", 3'd0, 2'd0, 1'b0, 2'd0, 16'h0002, 16'h0003, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
